matrix_result_streamer: RTL and testbench

Sequential read-out end of the 5x5 matrix multiplication ALU's flat result bus. On a start pulse it captures the 200-bit result matrix and its overflow flag. It then streams the 25 signed 8-bit elements one per transfer, in row-major order, over a valid/ready handshake. It sits between the multiplication ALU and the coprocessor's output/readback path, so that the result can be consumed byte-wise.

---
 rtl/matrix_result_streamer.sv | 101 ++++++++++
 tb/tb_matrix_result_streamer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_result_streamer.sv
// Captures the 5x5 multiplier result matrix on start and streams its elements
// row-major over a valid/ready handshake, tagging each with its row/column.
module matrix_result_streamer #(
  parameter  int DIM    = 5,
  parameter  int ELEM_W = 8,
  localparam int FLAT_W = DIM * DIM * ELEM_W,
  localparam int IDX_W  = $clog2(DIM),
  localparam int CNT_W  = $clog2(DIM * DIM)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [FLAT_W-1:0]        c_flat,
  input  logic                     overflow_in,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [ELEM_W-1:0] out_data,
  output logic [IDX_W-1:0]         out_row,
  output logic [IDX_W-1:0]         out_col,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done,
  output logic                     ovf_latched
);

  localparam logic [CNT_W-1:0] LAST_K  = CNT_W'(DIM * DIM - 1);
  localparam logic [IDX_W-1:0] COL_MAX = IDX_W'(DIM - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [IDX_W-1:0]   row;
  logic [IDX_W-1:0]   col;
  logic [FLAT_W-1:0]  cap;
  logic               ovf_q;

  function automatic logic signed [ELEM_W-1:0] elem_at(
    input logic [FLAT_W-1:0] m,
    input logic [CNT_W-1:0]  k
  );
    return $signed(m[int'(k) * ELEM_W +: ELEM_W]);
  endfunction

  // Row/column are tracked as separate counters so no divider is needed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
      row   <= '0;
      col   <= '0;
      cap   <= '0;
      ovf_q <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            cap   <= c_flat;
            ovf_q <= overflow_in;
            cnt   <= '0;
            row   <= '0;
            col   <= '0;
            state <= S_STREAM;
          end
        end
        S_STREAM: begin
          if (out_ready) begin
            if (cnt == LAST_K) begin
              state <= S_DONE;
            end else begin
              cnt <= cnt + 1'b1;
              if (col == COL_MAX) begin
                col <= '0;
                row <= row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Element fields are forced to zero outside STREAM so idle outputs are clean.
  assign out_valid   = (state == S_STREAM);
  assign out_data    = out_valid ? elem_at(cap, cnt) : '0;
  assign out_row     = out_valid ? row : '0;
  assign out_col     = out_valid ? col : '0;
  assign out_last    = out_valid && (cnt == LAST_K);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign ovf_latched = ovf_q;

endmodule

// File: tb/tb_matrix_result_streamer.sv
// Directed/randomized bench for matrix_result_streamer against a matrix-level
// reference model (captured 2D array walked row-major).
module tb_matrix_result_streamer;

  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int FLAT_W = DIM * DIM * ELEM_W;
  localparam int N      = DIM * DIM;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [FLAT_W-1:0] c_flat;
  logic              overflow_in;
  logic              out_ready;
  logic              out_valid;
  logic [ELEM_W-1:0] out_data;
  logic [2:0]        out_row;
  logic [2:0]        out_col;
  logic              out_last;
  logic              busy;
  logic              done;
  logic              ovf_latched;

  int checks = 0;
  int errors = 0;

  logic [7:0] src_mat [DIM][DIM];
  logic [7:0] exp_mat [DIM][DIM];
  logic       exp_ovf;

  always #5 clk = ~clk;

  matrix_result_streamer #(.DIM(DIM), .ELEM_W(ELEM_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .c_flat     (c_flat),
    .overflow_in(overflow_in),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_row    (out_row),
    .out_col    (out_col),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done),
    .ovf_latched(ovf_latched)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load_src();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        c_flat[(i * DIM + j) * ELEM_W +: ELEM_W] = src_mat[i][j];
  endtask

  task automatic fill_pattern();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        src_mat[i][j] = 8'(i * DIM + j - 12);
  endtask

  task automatic fill_random();
    for (int i = 0; i < DIM; i++)
      for (int j = 0; j < DIM; j++)
        src_mat[i][j] = 8'($urandom_range(0, 255));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_data"},  32'(out_data),  32'd0);
    chk({tag, "_row"},   32'(out_row),   32'd0);
    chk({tag, "_col"},   32'(out_col),   32'd0);
    chk({tag, "_last"},  32'(out_last),  32'd0);
    chk({tag, "_busy"},  32'(busy),      32'd0);
    chk({tag, "_done"},  32'(done),      32'd0);
  endtask

  // Model captures the current source matrix and flag at the accepted start edge.
  task automatic capture(input bit keep_start);
    exp_mat = src_mat;
    exp_ovf = overflow_in;
    start = 1'b1;
    tick();
    if (!keep_start) start = 1'b0;
  endtask

  // pat: 0 ready high, 1 ready 1,0,0 repeating, 2 random.
  // inject_k: transfer index at which a foreign start is pulsed (-1 none).
  // abort_k: stop streaming once this many transfers completed (-1 none).
  task automatic run_stream(input string tag, input int pat, input int inject_k, input int abort_k);
    int  k = 0;
    int  cyc = 0;
    bit  injected = 0;
    bit  r;
    while (k < N && !(abort_k >= 0 && k == abort_k)) begin
      assert (cyc < 400) else begin
        errors++;
        $error("FAIL %s_timeout: observed %0d cycles expected <400", tag, cyc);
        return;
      end
      case (pat)
        0:       r = 1'b1;
        1:       r = (cyc % 3 == 0);
        default: r = 1'($urandom_range(0, 1));
      endcase
      out_ready = r;
      if (!injected && inject_k == k) begin
        injected    = 1;
        c_flat      = {N{8'h7F}};
        overflow_in = 1'b0;
        start       = 1'b1;
      end else if (injected && start) begin
        start = 1'b0;
      end
      chk({tag, "_valid"}, 32'(out_valid),   32'd1);
      chk({tag, "_busy"},  32'(busy),        32'd1);
      chk({tag, "_done"},  32'(done),        32'd0);
      chk({tag, "_data"},  32'(out_data),    32'(exp_mat[k / DIM][k % DIM]));
      chk({tag, "_row"},   32'(out_row),     32'(k / DIM));
      chk({tag, "_col"},   32'(out_col),     32'(k % DIM));
      chk({tag, "_last"},  32'(out_last),    32'(k == N - 1));
      chk({tag, "_ovf"},   32'(ovf_latched), 32'(exp_ovf));
      if (r) k++;
      tick();
      cyc++;
    end
    if (abort_k >= 0) return;
    chk({tag, "_done_pulse"}, 32'(done),      32'd1);
    chk({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_done_busy"},  32'(busy),      32'd1);
    tick();
    chk({tag, "_after_done"}, 32'(done),        32'd0);
    chk({tag, "_after_busy"}, 32'(busy),        32'd0);
    chk({tag, "_after_vld"},  32'(out_valid),   32'd0);
    chk({tag, "_after_ovf"},  32'(ovf_latched), 32'(exp_ovf));
  endtask

  initial begin
    rst_n       = 1'b0;
    start       = 1'b0;
    c_flat      = '0;
    overflow_in = 1'b0;
    out_ready   = 1'b0;

    // Reset then idle
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check_idle("reset_idle");
      chk("reset_idle_ovf", 32'(ovf_latched), 32'd0);
      tick();
    end

    // Full stream, no backpressure
    fill_pattern();
    load_src();
    chk("pattern_00", 32'(c_flat[7:0]), 32'hF4);
    overflow_in = 1'b1;
    capture(0);
    run_stream("full", 0, -1, -1);

    // Backpressure with 1,0,0 ready pattern
    overflow_in = 1'b0;
    capture(0);
    run_stream("bp", 1, -1, -1);

    // Start ignored while busy
    load_src();
    overflow_in = 1'b1;
    capture(0);
    run_stream("ignore", 0, 10, -1);

    // Reset mid-stream after transfer 7
    fill_random();
    load_src();
    overflow_in = 1'b1;
    capture(0);
    run_stream("abort", 0, -1, 7);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_idle("abort_rst");
    chk("abort_rst_ovf", 32'(ovf_latched), 32'd0);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("abort_no_done", 32'(done), 32'd0);
    end
    fill_random();
    load_src();
    overflow_in = 1'b0;
    capture(0);
    run_stream("restart", 2, -1, -1);

    // Reset and start on the same edge: reset wins
    rst_n = 1'b0;
    start = 1'b1;
    overflow_in = 1'b1;
    tick();
    rst_n = 1'b1;
    start = 1'b0;
    check_idle("rst_start");
    chk("rst_start_ovf", 32'(ovf_latched), 32'd0);

    // Back-to-back with start held high
    fill_random();
    load_src();
    overflow_in = 1'b1;
    capture(1);
    fill_random();
    load_src();
    overflow_in = 1'b0;
    run_stream("b2b_a", 0, -1, -1);
    exp_mat = src_mat;
    exp_ovf = overflow_in;
    tick();
    start = 1'b0;
    run_stream("b2b_b", 0, -1, -1);

    // Random matrices with random backpressure
    for (int t = 0; t < 3; t++) begin
      fill_random();
      load_src();
      overflow_in = 1'($urandom_range(0, 1));
      capture(0);
      run_stream("rand", 2, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
